// File: rtl/core_launch_pkg.sv
// Shared types and default parameters for the core batch launcher.
package core_launch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CORE_RST,
    REQ,
    RUN,
    NEXT,
    FINISH
  } launch_state_t;

  localparam int NUM_PROGS_DEF  = 3;
  localparam int CNT_W_DEF      = 16;
  localparam int RST_CYCLES_DEF = 2;
  localparam int TIMEOUT_DEF    = 32'h0000_FFFF;

endpackage

// File: rtl/core_launcher.sv
// Batch run controller: resets the core, pulses req, times each run to done and stores counts.
// All outputs registered except rd_cycles; start is ignored while busy, done is ignored outside RUN.
module core_launcher
  import core_launch_pkg::*;
#(
  parameter int NUM_PROGS  = NUM_PROGS_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int PW         = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             core_reset,
  output logic             req,
  input  logic             done,
  output logic [PW-1:0]    prog_sel,
  output logic             busy,
  output logic             batch_done,
  output logic             timeout_err,
  input  logic [PW-1:0]    rd_idx,
  output logic [CNT_W-1:0] rd_cycles
);

  launch_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [PW-1:0]    prog_sel_q;
  logic             core_reset_q;
  logic             req_q;
  logic             busy_q;
  logic             batch_done_q;
  logic             timeout_err_q;
  logic [CNT_W-1:0] count_q [NUM_PROGS];

  // One counter serves both the reset-hold phase and the run timer.
  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      prog_sel_q    <= '0;
      core_reset_q  <= 1'b1;
      req_q         <= 1'b0;
      busy_q        <= 1'b0;
      batch_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < NUM_PROGS; i++) count_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_PROGS; i++) count_q[i] <= '0;
            timeout_err_q <= 1'b0;
            prog_sel_q    <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b1;
            state_q       <= CORE_RST;
          end
        end
        CORE_RST: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            core_reset_q <= 1'b0;
            req_q        <= 1'b1;
            state_q      <= REQ;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        REQ: begin
          req_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_d;
          // done wins over timeout when both land on the same cycle.
          if (done) begin
            for (int i = 0; i < NUM_PROGS; i++)
              if (prog_sel_q == PW'(i)) count_q[i] <= cnt_d;
            state_q <= NEXT;
          end else if (cnt_d == CNT_W'(TIMEOUT)) begin
            for (int i = 0; i < NUM_PROGS; i++)
              if (prog_sel_q == PW'(i)) count_q[i] <= cnt_d;
            timeout_err_q <= 1'b1;
            batch_done_q  <= 1'b1;
            core_reset_q  <= 1'b1;
            state_q       <= FINISH;
          end
        end
        NEXT: begin
          core_reset_q <= 1'b1;
          if (prog_sel_q == PW'(NUM_PROGS - 1)) begin
            batch_done_q <= 1'b1;
            state_q      <= FINISH;
          end else begin
            prog_sel_q <= prog_sel_q + PW'(1);
            cnt_q      <= '0;
            state_q    <= CORE_RST;
          end
        end
        FINISH: begin
          batch_done_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_cycles = '0;
    for (int i = 0; i < NUM_PROGS; i++)
      if (rd_idx == PW'(i)) rd_cycles = count_q[i];
  end

  assign core_reset  = core_reset_q;
  assign req         = req_q;
  assign prog_sel    = prog_sel_q;
  assign busy        = busy_q;
  assign batch_done  = batch_done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_core_launcher.sv
// Directed bench for core_launcher: NUM_PROGS=3, RST_CYCLES=2, TIMEOUT=20.
module tb_core_launcher;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        done = 1'b0;
  logic [1:0]  rd_idx = 2'd0;
  logic        core_reset, req, busy, batch_done, timeout_err;
  logic [1:0]  prog_sel;
  logic [15:0] rd_cycles;

  int checks = 0;
  int failures = 0;
  int req_cnt = 0;
  int bd_cnt = 0;

  core_launcher #(
    .NUM_PROGS (3),
    .CNT_W     (16),
    .RST_CYCLES(2),
    .TIMEOUT   (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .core_reset (core_reset),
    .req        (req),
    .done       (done),
    .prog_sel   (prog_sel),
    .busy       (busy),
    .batch_done (batch_done),
    .timeout_err(timeout_err),
    .rd_idx     (rd_idx),
    .rd_cycles  (rd_cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (req === 1'b1) req_cnt++;
    if (batch_done === 1'b1) bd_cnt++;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge of the req cycle; rst counts busy core_reset cycles just before it.
  task automatic wait_req(output bit ok, output int rst);
    ok = 1'b0;
    rst = 0;
    for (int i = 0; i < 60; i++) begin
      if (req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy === 1'b1 && core_reset === 1'b1) rst++;
      else rst = 0;
      @(negedge clk);
    end
  endtask

  task automatic drive_done(input int d);
    repeat (d) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic wait_bd(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      if (batch_done === 1'b1) begin
        ok = 1'b1;
        cyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic read_cnt(input logic [1:0] idx, output logic [15:0] v);
    rd_idx = idx;
    #1;
    v = rd_cycles;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checks++;
    if (core_reset !== 1'b1 || req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got core_reset=%b req=%b busy=%b exp 1/0/0", core_reset, req, busy);
    end
    checks++;
    if (batch_done !== 1'b0 || timeout_err !== 1'b0 || prog_sel !== 2'd0) begin
      failures++;
      $display("FAIL reset_flags got batch_done=%b timeout_err=%b prog_sel=%0d exp 0/0/0", batch_done, timeout_err, prog_sel);
    end
    for (int i = 0; i < 4; i++) begin
      read_cnt(2'(i), v);
      checks++;
      if (v !== 16'd0) begin
        failures++;
        $display("FAIL reset_rd_cycles[%0d] got=%0d exp=0", i, v);
      end
    end
  endtask

  task automatic test_batch();
    int d [3] = '{5, 7, 9};
    int r0, b0, rst, cyc;
    bit ok;
    logic [15:0] v;
    @(negedge clk);
    r0 = req_cnt;
    b0 = bd_cnt;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || core_reset !== 1'b1) begin
      failures++;
      $display("FAIL batch_busy_after_start got busy=%b core_reset=%b exp 1/1", busy, core_reset);
    end
    for (int p = 0; p < 3; p++) begin
      wait_req(ok, rst);
      checks++;
      if (!ok || rst != 2) begin
        failures++;
        $display("FAIL batch_req%0d got ok=%0d rst_cycles=%0d exp 1/2", p, ok, rst);
      end
      checks++;
      if (prog_sel !== 2'(p)) begin
        failures++;
        $display("FAIL batch_prog_sel%0d got=%0d exp=%0d", p, prog_sel, p);
      end
      drive_done(d[p]);
    end
    wait_bd(ok, cyc);
    checks++;
    if (!ok || cyc != 1) begin
      failures++;
      $display("FAIL batch_done_timing got ok=%0d cyc=%0d exp 1/1", ok, cyc);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || batch_done !== 1'b0 || prog_sel !== 2'd2) begin
      failures++;
      $display("FAIL batch_end got busy=%b batch_done=%b prog_sel=%0d exp 0/0/2", busy, batch_done, prog_sel);
    end
    checks++;
    if (req_cnt - r0 != 3 || bd_cnt - b0 != 1 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL batch_pulses got req=%0d bd=%0d terr=%b exp 3/1/0", req_cnt - r0, bd_cnt - b0, timeout_err);
    end
    for (int p = 0; p < 3; p++) begin
      read_cnt(2'(p), v);
      checks++;
      if (v !== 16'(d[p])) begin
        failures++;
        $display("FAIL batch_rd_cycles[%0d] got=%0d exp=%0d", p, v, d[p]);
      end
    end
  endtask

  task automatic test_stale_done();
    int rst, cyc;
    bit ok;
    logic [15:0] v;
    @(negedge clk);
    done = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stale_idle_busy got=%b exp=0", busy);
    end
    pulse_start();
    wait_req(ok, rst);
    checks++;
    if (!ok || rst != 2) begin
      failures++;
      $display("FAIL stale_req got ok=%0d rst_cycles=%0d exp 1/2", ok, rst);
    end
    @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);
    read_cnt(2'd0, v);
    checks++;
    if (v !== 16'd0) begin
      failures++;
      $display("FAIL stale_early_capture got=%0d exp=0", v);
    end
    repeat (2) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_req(ok, rst);
    drive_done(2);
    wait_req(ok, rst);
    drive_done(3);
    wait_bd(ok, cyc);
    @(negedge clk);
    read_cnt(2'd0, v);
    checks++;
    if (v !== 16'd5) begin
      failures++;
      $display("FAIL stale_count0 got=%0d exp=5", v);
    end
    read_cnt(2'd2, v);
    checks++;
    if (v !== 16'd3) begin
      failures++;
      $display("FAIL stale_count2 got=%0d exp=3", v);
    end
  endtask

  task automatic test_ignore();
    int r0, r1, rst, cyc;
    bit ok;
    logic [15:0] v;
    @(negedge clk);
    r0 = req_cnt;
    pulse_start();
    wait_req(ok, rst);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_req(ok, rst);
    drive_done(2);
    wait_req(ok, rst);
    drive_done(3);
    wait_bd(ok, cyc);
    @(negedge clk);
    read_cnt(2'd0, v);
    checks++;
    if (v !== 16'd6 || req_cnt - r0 != 3) begin
      failures++;
      $display("FAIL ignore_start_in_run got count0=%0d reqs=%0d exp 6/3", v, req_cnt - r0);
    end
    r1 = req_cnt;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || core_reset !== 1'b1 || req_cnt - r1 != 0) begin
      failures++;
      $display("FAIL ignore_done_in_idle got busy=%b core_reset=%b reqs=%0d exp 0/1/0", busy, core_reset, req_cnt - r1);
    end
    read_cnt(2'd3, v);
    checks++;
    if (v !== 16'd0) begin
      failures++;
      $display("FAIL rd_idx_out_of_range got=%0d exp=0", v);
    end
  endtask

  task automatic test_timeout();
    int r0, b0, rst, cyc;
    bit ok;
    logic [15:0] v;
    @(negedge clk);
    r0 = req_cnt;
    b0 = bd_cnt;
    pulse_start();
    wait_req(ok, rst);
    wait_bd(ok, cyc);
    checks++;
    if (!ok || cyc != 21 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_finish got ok=%0d cyc=%0d terr=%b exp 1/21/1", ok, cyc, timeout_err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky got busy=%b terr=%b exp 0/1", busy, timeout_err);
    end
    checks++;
    if (req_cnt - r0 != 1 || bd_cnt - b0 != 1) begin
      failures++;
      $display("FAIL timeout_pulses got req=%0d bd=%0d exp 1/1", req_cnt - r0, bd_cnt - b0);
    end
    read_cnt(2'd0, v);
    checks++;
    if (v !== 16'd20) begin
      failures++;
      $display("FAIL timeout_count0 got=%0d exp=20", v);
    end
    read_cnt(2'd1, v);
    checks++;
    if (v !== 16'd0) begin
      failures++;
      $display("FAIL timeout_count1 got=%0d exp=0", v);
    end
    pulse_start();
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear_on_start got=%b exp=0", timeout_err);
    end
    for (int p = 0; p < 3; p++) begin
      wait_req(ok, rst);
      drive_done(1);
    end
    wait_bd(ok, cyc);
    @(negedge clk);
    read_cnt(2'd0, v);
    checks++;
    if (v !== 16'd1) begin
      failures++;
      $display("FAIL first_run_cycle_done got=%0d exp=1", v);
    end
  endtask

  task automatic test_timeout_edge();
    int r0, rst, cyc;
    bit ok;
    logic [15:0] v;
    @(negedge clk);
    r0 = req_cnt;
    pulse_start();
    wait_req(ok, rst);
    drive_done(20);
    wait_req(ok, rst);
    drive_done(1);
    wait_req(ok, rst);
    drive_done(1);
    wait_bd(ok, cyc);
    @(negedge clk);
    read_cnt(2'd0, v);
    checks++;
    if (v !== 16'd20 || timeout_err !== 1'b0 || req_cnt - r0 != 3) begin
      failures++;
      $display("FAIL done_at_timeout got count0=%0d terr=%b reqs=%0d exp 20/0/3", v, timeout_err, req_cnt - r0);
    end
  endtask

  task automatic test_reset_midrun();
    int r0, rst;
    bit ok;
    logic [15:0] v;
    @(negedge clk);
    pulse_start();
    wait_req(ok, rst);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checks++;
    if (core_reset !== 1'b1 || req !== 1'b0 || busy !== 1'b0 || prog_sel !== 2'd0) begin
      failures++;
      $display("FAIL midrun_reset got core_reset=%b req=%b busy=%b prog_sel=%0d exp 1/0/0/0", core_reset, req, busy, prog_sel);
    end
    for (int i = 0; i < 4; i++) begin
      read_cnt(2'(i), v);
      checks++;
      if (v !== 16'd0) begin
        failures++;
        $display("FAIL midrun_rd_cycles[%0d] got=%0d exp=0", i, v);
      end
    end
    r0 = req_cnt;
    repeat (10) @(negedge clk);
    checks++;
    if (req_cnt - r0 != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrun_stays_idle got reqs=%0d busy=%b exp 0/0", req_cnt - r0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_batch();
    test_stale_done();
    test_ignore();
    test_timeout();
    test_timeout_edge();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_launcher.md
# core_launcher

Batch run controller that drives the processor core's `req`/`done` handshake from the initiator side. On a host `start`, it walks the program indices 0..NUM_PROGS-1. For each program it holds the core in reset, issues a one-cycle `req`, and times the run until `done`. Per-program cycle counts are stored for readback. It sits above `top_level` in the test/system harness and replaces hand-written req/done sequencing in benches.

## Interface
Parameters:
- `NUM_PROGS`, 3: programs per batch (≥1).
- `CNT_W`, 16: cycle counter width.
- `RST_CYCLES`, 2: minimum cycles `core_reset` is held before each `req` (≥1).
- `TIMEOUT`, 16'hFFFF: maximum run length in cycles (≤2^CNT_W−1).
- `PW`, $clog2(NUM_PROGS) (min 1): index width.

Ports:
- `clk` in 1: the single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: batch request, sampled only in IDLE.
- `core_reset` out 1: active-high reset to the core.
- `req` out 1: one-cycle run request to the core.
- `done` in 1: core completion level.
- `prog_sel` out PW: current program index.
- `busy` out 1: high in any state other than IDLE.
- `batch_done` out 1: one-cycle pulse at the end of a batch.
- `timeout_err` out 1: sticky; cleared by the next accepted `start`.
- `rd_idx` in PW: readback index.
- `rd_cycles` out CNT_W: combinational read of the count for `rd_idx`. Returns 0 for `rd_idx` ≥ NUM_PROGS.

## Operation
- Reset (`reset`=0 at an edge):
  - state=IDLE.
  - `core_reset`=1; `req`=0; `busy`=0; `batch_done`=0; `timeout_err`=0; `prog_sel`=0.
  - All counts and the run counter cleared to 0.
  - Takes effect from any state, including mid-run; no partial count is stored.
- States:
  - IDLE: `core_reset`=1. When `start`=1: clear counts and `timeout_err`, set `prog_sel`=0, go to CORE_RST.
  - CORE_RST: `core_reset`=1 for exactly RST_CYCLES cycles, then go to REQ.
  - REQ: `core_reset`=0, `req`=1 for one cycle, run counter ← 0, go to RUN.
  - RUN: counter increments by 1 each cycle, giving n=1 in the first RUN cycle.
    - If `done`=1: store n into count[`prog_sel`], go to NEXT.
    - Else if n==TIMEOUT: store TIMEOUT, set `timeout_err`=1, go to FINISH. The batch is aborted and later programs are not run; their counts stay 0.
  - NEXT: if `prog_sel`==NUM_PROGS−1, go to FINISH. Else `prog_sel`+1, go to CORE_RST.
  - FINISH: `batch_done`=1 for one cycle, `core_reset`=1, go to IDLE. `prog_sel` holds its last value until the next start.
- `done` is ignored outside RUN, including a stale `done` high during REQ.
- `start` is ignored while `busy`.
- The counter saturates and never wraps, because TIMEOUT ≤ 2^CNT_W−1.
- A `done` arriving in the same cycle that n reaches TIMEOUT is a success: n is stored and `timeout_err` is not set.

## Timing
- All outputs except `rd_cycles` are registered.
- `start` sampled at edge k:
  - `busy` and `core_reset` are high from k+1 through k+RST_CYCLES.
  - `req`=1 in cycle k+RST_CYCLES+1.
- `done` is first sampled in the cycle after `req`.
  - The count equals the number of cycles from `req` (exclusive) to `done` (inclusive).
  - The count is readable in the cycle after capture.
- Each further program adds RST_CYCLES+1 (rst+req) + n (RUN) + 1 (NEXT) cycles.
- `batch_done` follows the final NEXT, or the timeout cycle, by one cycle. `busy` falls in the same cycle `batch_done` falls.

## Structure
- Package `core_launch_pkg`:
  - `launch_state_t` enum: IDLE, CORE_RST, REQ, RUN, NEXT, FINISH.
  - Default-parameter localparams.
- Single module `core_launcher`. No sub-module: the reset-hold counter and the run counter share one CNT_W register.

## Test plan
- Reset held low for 2 cycles, from idle and again mid-RUN → the next cycle shows IDLE, `core_reset`=1, `req`=0, `busy`=0, and `rd_cycles`=0 for all indices.
- Core model raises `done` 5, 7 and 9 cycles after each `req` → exactly 3 `req` pulses, each preceded by 2 `core_reset` cycles; `prog_sel` steps 0,1,2; `rd_cycles` reads 5,7,9; one `batch_done` pulse; `timeout_err`=0.
- TIMEOUT=20, `done` never rises → count[0]=20, `timeout_err`=1, no `req` for program 1, `batch_done` pulses once. The next `start` clears `timeout_err`.
- `done` held high through IDLE, CORE_RST and REQ, dropped in the first RUN cycle, then raised 4 cycles later → count=5; no early capture.
- `done` high in the first RUN cycle → count=1. `done` rising exactly at n=TIMEOUT → count=TIMEOUT with `timeout_err`=0.
- `start` pulsed again during RUN and `done` pulsed in IDLE → no state change and no extra `req`. `rd_idx`=3 with NUM_PROGS=3 → `rd_cycles`=0.
